rv32_instr_encoder: RTL and testbench

// - Inverse of the RV32I decode stage: turns decoded micro-op commands (kind, alu_op, regs, imm)

---
 rtl/rv32_pkg.sv | 64 ++++++
 rtl/rv32_encode_word.sv | 110 +++++++++++
 rtl/rv32_instr_encoder.sv | 139 +++++++++++++
 tb/tb_rv32_instr_encoder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I encode/decode definitions: opcodes, funct fields, command kinds and the alu_op map.
// IMM_RANGE_CHECK_EN enables the immediate-fit helpers' use in rv32_encode_word.
package rv32_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;

    typedef enum logic [2:0] {
        KIND_R     = 3'd0,
        KIND_I     = 3'd1,
        KIND_LOAD  = 3'd2,
        KIND_STORE = 3'd3,
        KIND_JAL   = 3'd4,
        KIND_JALR  = 3'd5
    } cmd_kind_e;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_SLL   = 5'd2,
        ALU_SLT   = 5'd3,
        ALU_SLTU  = 5'd4,
        ALU_XOR   = 5'd5,
        ALU_SRL   = 5'd6,
        ALU_SRA   = 5'd7,
        ALU_OR    = 5'd8,
        ALU_AND   = 5'd9,
        ALU_ADDI  = 5'd10,
        ALU_SLLI  = 5'd11,
        ALU_SLTI  = 5'd12,
        ALU_SLTIU = 5'd13,
        ALU_XORI  = 5'd14,
        ALU_SRLI  = 5'd15,
        ALU_SRAI  = 5'd16,
        ALU_ORI   = 5'd17,
        ALU_ANDI  = 5'd18
    } alu_op_e;

    function automatic logic simm12_fits(input logic [31:0] v);
        return (v[31:11] == {21{v[11]}});
    endfunction

    function automatic logic simm21_fits(input logic [31:0] v);
        return (v[31:20] == {12{v[20]}});
    endfunction

endpackage

// File: rtl/rv32_encode_word.sv
// Combinational micro-op -> RV32I word encoder with illegal-command detection.
// IMM_RANGE_CHECK_EN additionally rejects immediates that do not fit their field.
module rv32_encode_word
    import rv32_pkg::*;
(
    input  logic [2:0]  i_kind,
    input  logic [4:0]  i_alu_op,
    input  logic [2:0]  i_width,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_r_ok;
    logic       w_i_ok;
    logic       w_is_shift;
    logic       w_bad_simm12;
    logic       w_bad_shamt;
    logic       w_bad_jal;
    logic       w_unused_imm;

`ifdef IMM_RANGE_CHECK_EN
    assign w_bad_simm12 = !simm12_fits(i_imm);
    assign w_bad_shamt  = (i_imm[31:5] != 27'd0);
    assign w_bad_jal    = !simm21_fits(i_imm) || i_imm[0];
`else
    assign w_bad_simm12 = 1'b0;
    assign w_bad_shamt  = 1'b0;
    assign w_bad_jal    = 1'b0;
`endif
    assign w_unused_imm = ^{i_imm[31:21], i_imm[0]};

    // alu_op -> funct3/funct7 and which command kind the op belongs to
    always_comb begin
        w_f3       = F3_ADD;
        w_f7       = F7_BASE;
        w_r_ok     = 1'b0;
        w_i_ok     = 1'b0;
        w_is_shift = 1'b0;
        case (i_alu_op)
            ALU_ADD:   begin w_f3 = F3_ADD;  w_r_ok = 1'b1; end
            ALU_SUB:   begin w_f3 = F3_ADD;  w_f7 = F7_ALT; w_r_ok = 1'b1; end
            ALU_SLL:   begin w_f3 = F3_SLL;  w_r_ok = 1'b1; end
            ALU_SLT:   begin w_f3 = F3_SLT;  w_r_ok = 1'b1; end
            ALU_SLTU:  begin w_f3 = F3_SLTU; w_r_ok = 1'b1; end
            ALU_XOR:   begin w_f3 = F3_XOR;  w_r_ok = 1'b1; end
            ALU_SRL:   begin w_f3 = F3_SR;   w_r_ok = 1'b1; end
            ALU_SRA:   begin w_f3 = F3_SR;   w_f7 = F7_ALT; w_r_ok = 1'b1; end
            ALU_OR:    begin w_f3 = F3_OR;   w_r_ok = 1'b1; end
            ALU_AND:   begin w_f3 = F3_AND;  w_r_ok = 1'b1; end
            ALU_ADDI:  begin w_f3 = F3_ADD;  w_i_ok = 1'b1; end
            ALU_SLLI:  begin w_f3 = F3_SLL;  w_i_ok = 1'b1; w_is_shift = 1'b1; end
            ALU_SLTI:  begin w_f3 = F3_SLT;  w_i_ok = 1'b1; end
            ALU_SLTIU: begin w_f3 = F3_SLTU; w_i_ok = 1'b1; end
            ALU_XORI:  begin w_f3 = F3_XOR;  w_i_ok = 1'b1; end
            ALU_SRLI:  begin w_f3 = F3_SR;   w_i_ok = 1'b1; w_is_shift = 1'b1; end
            ALU_SRAI:  begin w_f3 = F3_SR;   w_f7 = F7_ALT; w_i_ok = 1'b1; w_is_shift = 1'b1; end
            ALU_ORI:   begin w_f3 = F3_OR;   w_i_ok = 1'b1; end
            ALU_ANDI:  begin w_f3 = F3_AND;  w_i_ok = 1'b1; end
            default:   begin w_f3 = F3_ADD;  w_f7 = F7_BASE; end
        endcase
    end

    // Field packing per instruction format
    always_comb begin
        o_word    = 32'h0000_0000;
        o_illegal = 1'b0;
        case (i_kind)
            KIND_R: begin
                o_word    = {w_f7, i_rs2, i_rs1, w_f3, i_rd, OPC_OP};
                o_illegal = !w_r_ok;
            end
            KIND_I: begin
                if (w_is_shift) begin
                    o_word    = {w_f7, i_imm[4:0], i_rs1, w_f3, i_rd, OPC_OP_IMM};
                    o_illegal = !w_i_ok || w_bad_shamt;
                end else begin
                    o_word    = {i_imm[11:0], i_rs1, w_f3, i_rd, OPC_OP_IMM};
                    o_illegal = !w_i_ok || w_bad_simm12;
                end
            end
            KIND_LOAD: begin
                o_word    = {i_imm[11:0], i_rs1, i_width, i_rd, OPC_LOAD};
                o_illegal = (i_width == 3'd3) || (i_width > 3'd5) || w_bad_simm12;
            end
            KIND_STORE: begin
                o_word    = {i_imm[11:5], i_rs2, i_rs1, i_width, i_imm[4:0], OPC_STORE};
                o_illegal = (i_width > 3'd2) || w_bad_simm12;
            end
            KIND_JAL: begin
                o_word    = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OPC_JAL};
                o_illegal = w_bad_jal;
            end
            KIND_JALR: begin
                o_word    = {i_imm[11:0], i_rs1, F3_JALR, i_rd, OPC_JALR};
                o_illegal = w_bad_simm12;
            end
            default: begin
                o_word    = 32'h0000_0000;
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rv32_instr_encoder.sv
// RV32I instruction encoder: command stream in, {word, byte address} stream out via a 2-entry skid FIFO.
// Build with IMM_RANGE_CHECK_EN defined to reject out-of-range immediates as illegal.
module rv32_instr_encoder
    import rv32_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_kind,
    input  logic [4:0]        cmd_alu_op,
    input  logic [2:0]        cmd_width,
    input  logic [4:0]        cmd_rd,
    input  logic [4:0]        cmd_rs1,
    input  logic [4:0]        cmd_rs2,
    input  logic [31:0]       cmd_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              err_illegal,
    input  logic              err_clear,
    output logic [CNT_W-1:0]  instr_count
);

    localparam logic [ADDR_W-1:0] ADDR_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

    logic              r_out_valid;
    logic [31:0]       r_out_instr;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_skid_valid;
    logic [31:0]       r_skid_instr;
    logic [ADDR_W-1:0] r_skid_addr;
    logic [ADDR_W-1:0] r_addr_cnt;
    logic              r_err;
    logic [CNT_W-1:0]  r_count;

    logic [31:0]       w_word;
    logic              w_illegal;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_base_aligned;
    logic [ADDR_W-1:0] w_slot_addr;
    logic              w_unused_base;

    rv32_encode_word u_encode (
        .i_kind    (cmd_kind),
        .i_alu_op  (cmd_alu_op),
        .i_width   (cmd_width),
        .i_rd      (cmd_rd),
        .i_rs1     (cmd_rs1),
        .i_rs2     (cmd_rs2),
        .i_imm     (cmd_imm),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    // The skid slot is only ever occupied behind a valid head, so it alone marks "full".
    assign cmd_ready      = !(r_out_valid && r_skid_valid);
    assign w_accept       = cmd_valid && cmd_ready;
    assign w_push         = w_accept && !w_illegal;
    assign w_pop          = r_out_valid && out_ready;
    assign w_base_aligned = {base_addr[ADDR_W-1:2], 2'b00};
    assign w_slot_addr    = base_load ? w_base_aligned : r_addr_cnt;
    assign w_unused_base  = ^base_addr[1:0];

    // Head (output) register and skid entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_instr  <= 32'h0000_0000;
            r_out_addr   <= {ADDR_W{1'b0}};
            r_skid_valid <= 1'b0;
            r_skid_instr <= 32'h0000_0000;
            r_skid_addr  <= {ADDR_W{1'b0}};
        end else if (!r_out_valid || w_pop) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_instr  <= r_skid_instr;
                r_out_addr   <= r_skid_addr;
                r_skid_valid <= 1'b0;
            end else if (w_push) begin
                r_out_valid  <= 1'b1;
                r_out_instr  <= w_word;
                r_out_addr   <= w_slot_addr;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_push) begin
            r_skid_valid <= 1'b1;
            r_skid_instr <= w_word;
            r_skid_addr  <= w_slot_addr;
        end else begin
            r_skid_valid <= r_skid_valid;
        end
    end

    // Address counter, sticky illegal flag (set beats clear) and emitted-word count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr_cnt <= {ADDR_W{1'b0}};
            r_err      <= 1'b0;
            r_count    <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_addr_cnt <= w_slot_addr + ADDR_STEP;
            end else if (base_load) begin
                r_addr_cnt <= w_base_aligned;
            end else begin
                r_addr_cnt <= r_addr_cnt;
            end
            if (w_accept && w_illegal) begin
                r_err <= 1'b1;
            end else if (err_clear) begin
                r_err <= 1'b0;
            end else begin
                r_err <= r_err;
            end
            if (w_pop) begin
                r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_count <= r_count;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_instr   = r_out_instr;
    assign out_addr    = r_out_addr;
    assign err_illegal = r_err;
    assign instr_count = r_count;

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Directed self-checking bench for rv32_instr_encoder (hand-computed RV32I words and addresses).
module tb_rv32_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_kind;
    logic [4:0]  cmd_alu_op;
    logic [2:0]  cmd_width;
    logic [4:0]  cmd_rd;
    logic [4:0]  cmd_rs1;
    logic [4:0]  cmd_rs2;
    logic [31:0] cmd_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        base_load;
    logic [31:0] base_addr;
    logic        err_illegal;
    logic        err_clear;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  op;
        logic [2:0]  width;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];
    vec_t bad[6];

    rv32_instr_encoder #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_kind    (cmd_kind),
        .cmd_alu_op  (cmd_alu_op),
        .cmd_width   (cmd_width),
        .cmd_rd      (cmd_rd),
        .cmd_rs1     (cmd_rs1),
        .cmd_rs2     (cmd_rs2),
        .cmd_imm     (cmd_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_addr    (out_addr),
        .base_load   (base_load),
        .base_addr   (base_addr),
        .err_illegal (err_illegal),
        .err_clear   (err_clear),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input vec_t v);
        cmd_kind   = v.kind;
        cmd_alu_op = v.op;
        cmd_width  = v.width;
        cmd_rd     = v.rd;
        cmd_rs1    = v.rs1;
        cmd_rs2    = v.rs2;
        cmd_imm    = v.imm;
    endtask

    task automatic issue(input vec_t v);
        set_cmd(v);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        vec_t big;
        //           kind  op     width rd     rs1    rs2    imm            expected word
        vecs[0]  = '{3'd0, 5'd0,  3'd0, 5'd3,  5'd1,  5'd2,  32'h0000_0000, 32'h0020_81B3}; // ADD
        vecs[1]  = '{3'd0, 5'd1,  3'd0, 5'd3,  5'd1,  5'd2,  32'h0000_0000, 32'h4020_81B3}; // SUB
        vecs[2]  = '{3'd1, 5'd10, 3'd0, 5'd5,  5'd0,  5'd0,  32'hFFFF_FFFF, 32'hFFF0_0293}; // ADDI -1
        vecs[3]  = '{3'd1, 5'd16, 3'd0, 5'd4,  5'd4,  5'd0,  32'h0000_0003, 32'h4032_5213}; // SRAI 3
        vecs[4]  = '{3'd2, 5'd0,  3'd2, 5'd6,  5'd1,  5'd0,  32'h0000_0004, 32'h0040_A303}; // LW
        vecs[5]  = '{3'd3, 5'd0,  3'd2, 5'd0,  5'd1,  5'd2,  32'h0000_0008, 32'h0020_A423}; // SW
        vecs[6]  = '{3'd4, 5'd0,  3'd0, 5'd1,  5'd0,  5'd0,  32'h0000_0008, 32'h0080_00EF}; // JAL +8
        vecs[7]  = '{3'd5, 5'd0,  3'd0, 5'd1,  5'd5,  5'd0,  32'hFFFF_FFFC, 32'hFFC2_80E7}; // JALR -4
        vecs[8]  = '{3'd1, 5'd11, 3'd0, 5'd2,  5'd3,  5'd0,  32'h0000_0007, 32'h0071_9113}; // SLLI 7
        vecs[9]  = '{3'd0, 5'd9,  3'd0, 5'd31, 5'd30, 5'd29, 32'h0000_0000, 32'h01DF_7FB3}; // AND
        vecs[10] = '{3'd4, 5'd0,  3'd0, 5'd0,  5'd0,  5'd0,  32'h0000_0800, 32'h0010_006F}; // JAL imm[11]
        vecs[11] = '{3'd1, 5'd17, 3'd0, 5'd7,  5'd8,  5'd0,  32'h0000_00FF, 32'h0FF4_6393}; // ORI 0xFF

        bad[0] = '{3'd7, 5'd0,  3'd0, 5'd1, 5'd1, 5'd1, 32'h0, 32'h0};
        bad[1] = '{3'd6, 5'd0,  3'd0, 5'd1, 5'd1, 5'd1, 32'h0, 32'h0};
        bad[2] = '{3'd0, 5'd12, 3'd0, 5'd1, 5'd1, 5'd1, 32'h0, 32'h0};
        bad[3] = '{3'd1, 5'd3,  3'd0, 5'd1, 5'd1, 5'd1, 32'h0, 32'h0};
        bad[4] = '{3'd2, 5'd0,  3'd3, 5'd1, 5'd1, 5'd1, 32'h0, 32'h0};
        bad[5] = '{3'd3, 5'd0,  3'd3, 5'd1, 5'd1, 5'd1, 32'h0, 32'h0};

        rst_n = 1'b0; cmd_valid = 1'b0; out_ready = 1'b1;
        base_load = 1'b0; base_addr = 32'h0; err_clear = 1'b0;
        set_cmd(vecs[0]);
        tick(); tick(); tick();
        rst_n = 1'b1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_instr", out_instr, 32'd0);
        check_eq("rst_out_addr", out_addr, 32'd0);
        check_eq("rst_err", {31'd0, err_illegal}, 32'd0);
        check_eq("rst_count", {16'd0, instr_count}, 32'd0);
        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i]);
            check_eq($sformatf("enc_valid_%0d", i), {31'd0, out_valid}, 32'd1);
            check_eq($sformatf("enc_word_%0d", i), out_instr, vecs[i].exp);
            check_eq($sformatf("enc_addr_%0d", i), out_addr, 32'(i * 4));
            tick();
        end
        check_eq("drain_valid", {31'd0, out_valid}, 32'd0);
        check_eq("count_12", {16'd0, instr_count}, 32'd12);

        // backpressure: third command must be held while two are buffered
        out_ready = 1'b0;
        issue(vecs[0]);
        issue(vecs[1]);
        check_eq("bp_full_ready", {31'd0, cmd_ready}, 32'd0);
        set_cmd(vecs[2]);
        cmd_valid = 1'b1;
        tick();
        check_eq("bp_held_ready", {31'd0, cmd_ready}, 32'd0);
        check_eq("bp_head_word", out_instr, vecs[0].exp);
        check_eq("bp_head_addr", out_addr, 32'h30);
        tick();
        check_eq("bp_stable_word", out_instr, vecs[0].exp);
        check_eq("bp_stable_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        check_eq("bp_second_word", out_instr, vecs[1].exp);
        check_eq("bp_second_addr", out_addr, 32'h34);
        check_eq("bp_ready_again", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        check_eq("bp_third_word", out_instr, vecs[2].exp);
        check_eq("bp_third_addr", out_addr, 32'h38);
        tick();
        check_eq("bp_drain_valid", {31'd0, out_valid}, 32'd0);
        check_eq("bp_count", {16'd0, instr_count}, 32'd15);

        for (int i = 0; i < 6; i++) begin
            issue(bad[i]);
            check_eq($sformatf("ill_no_out_%0d", i), {31'd0, out_valid}, 32'd0);
            check_eq($sformatf("ill_err_%0d", i), {31'd0, err_illegal}, 32'd1);
            err_clear = 1'b1;
            tick();
            err_clear = 1'b0;
            check_eq($sformatf("ill_clear_%0d", i), {31'd0, err_illegal}, 32'd0);
        end
        err_clear = 1'b1;
        issue(bad[0]);
        err_clear = 1'b0;
        check_eq("ill_set_wins", {31'd0, err_illegal}, 32'd1);
        issue(vecs[0]);
        check_eq("ill_addr_kept", out_addr, 32'h3C);
        check_eq("ill_err_sticky", {31'd0, err_illegal}, 32'd1);
        tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        big = '{3'd1, 5'd10, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h8000_0093};
        issue(big);
`ifdef IMM_RANGE_CHECK_EN
        check_eq("imm_range_err", {31'd0, err_illegal}, 32'd1);
        check_eq("imm_range_drop", {31'd0, out_valid}, 32'd0);
`else
        check_eq("imm_trunc_err", {31'd0, err_illegal}, 32'd0);
        check_eq("imm_trunc_word", out_instr, big.exp);
        check_eq("imm_trunc_addr", out_addr, 32'h40);
`endif
        tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        base_load = 1'b1;
        base_addr = 32'h0000_1003;
        issue(vecs[0]);
        base_load = 1'b0;
        check_eq("base_addr0", out_addr, 32'h1000);
        tick();
        issue(vecs[1]);
        check_eq("base_addr1", out_addr, 32'h1004);
        check_eq("base_word1", out_instr, vecs[1].exp);
        tick();

        // reset with buffered words and a pending error
        out_ready = 1'b0;
        issue(bad[0]);
        issue(vecs[2]);
        issue(vecs[3]);
        rst_n = 1'b0;
        tick();
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_instr", out_instr, 32'd0);
        check_eq("mid_rst_addr", out_addr, 32'd0);
        check_eq("mid_rst_err", {31'd0, err_illegal}, 32'd0);
        check_eq("mid_rst_count", {16'd0, instr_count}, 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        check_eq("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        issue(vecs[9]);
        check_eq("post_rst_addr", out_addr, 32'd0);
        check_eq("post_rst_word", out_instr, vecs[9].exp);
        tick();
        check_eq("post_rst_count", {16'd0, instr_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
